pipelined_add3: RTL and testbench

//  - Two-stage pipelined three-operand unsigned adder: z = a + b + c, truncated to WIDTH bits.
//  - Intermediate sum a+b is registered to split the carry chain. Full throughput: one new

---
 rtl/pipelined_add3.sv | 30 +++
 tb/tb_pipelined_add3.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipelined_add3.sv
// Two-stage pipelined three-operand unsigned adder: z = (a + b + c) mod 2^WIDTH.
// The a+b partial sum is registered to split the carry chain; one operand set per clock.
module pipelined_add3 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] z
);

    logic [WIDTH-1:0] s1_sum;
    logic [WIDTH-1:0] s1_c;

    // Carries out of the top bit are dropped at both stages, so results wrap modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_sum <= '0;
            s1_c   <= '0;
            z      <= '0;
        end else begin
            s1_sum <= a + b;
            s1_c   <= c;
            z      <= s1_sum + s1_c;
        end
    end

endmodule

// File: tb/tb_pipelined_add3.sv
// Self-checking bench for pipelined_add3: directed vector table, streaming/reset
// sequences and a random stream compared against a two-cycle-delayed reference.
module tb_pipelined_add3;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] z;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] z;
    } vec_t;

    vec_t tbl [8];

    pipelined_add3 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: z=%0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and land 1ns after it, where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vc);
        a = va;
        b = vb;
        c = vc;
    endtask

    initial begin
        logic [WIDTH-1:0] prev_exp;
        logic [WIDTH-1:0] cur_exp;
        logic [WIDTH-1:0] ra, rb, rc;
        logic [WIDTH-1:0] z_hold;

        n_checks = 0;
        n_fail   = 0;

        tbl[0] = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   z: 8'd6};
        tbl[1] = '{a: 8'd2,   b: 8'd3,   c: 8'd4,   z: 8'd9};
        tbl[2] = '{a: 8'd3,   b: 8'd4,   c: 8'd5,   z: 8'd12};
        tbl[3] = '{a: 8'd4,   b: 8'd5,   c: 8'd6,   z: 8'd15};
        tbl[4] = '{a: 8'd5,   b: 8'd6,   c: 8'd7,   z: 8'd18};
        tbl[5] = '{a: 8'd200, b: 8'd100, c: 8'd0,   z: 8'd44};
        tbl[6] = '{a: 8'd255, b: 8'd255, c: 8'd255, z: 8'd253};
        tbl[7] = '{a: 8'd255, b: 8'd1,   c: 8'd0,   z: 8'd0};

        // Reset with non-zero operands present: z must stay 0.
        rst_n = 1'b0;
        drive(8'd9, 8'd9, 8'd9);
        #1;
        tick();
        check("reset_edge1", z, 8'd0);
        tick();
        check("reset_edge2", z, 8'd0);

        // Held vectors: first edge still shows the previous result, then the new one for two edges.
        rst_n    = 1'b1;
        prev_exp = 8'd0;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].c);
            tick();
            check($sformatf("vec%0d_edge1", i), z, prev_exp);
            tick();
            check($sformatf("vec%0d_edge2", i), z, tbl[i].z);
            tick();
            check($sformatf("vec%0d_edge3", i), z, tbl[i].z);
            prev_exp = tbl[i].z;
        end

        // Input changes between edges must not reach z.
        z_hold = z;
        drive(8'd77, 8'd88, 8'd99);
        #2;
        check("no_comb_path", z, z_hold);
        drive(8'd255, 8'd1, 8'd0);
        #1;

        // Streaming: one set per cycle, results on consecutive cycles with 2-edge latency.
        drive(8'd1, 8'd2, 8'd3);
        tick();
        check("stream_e1", z, 8'd0);
        drive(8'd2, 8'd3, 8'd4);
        tick();
        check("stream_e2", z, 8'd6);
        drive(8'd3, 8'd4, 8'd5);
        tick();
        check("stream_e3", z, 8'd9);
        tick();
        check("stream_e4", z, 8'd12);

        // Reset one edge after 5,6,7 is captured: 18 must be discarded.
        drive(8'd5, 8'd6, 8'd7);
        tick();
        check("midrst_capture", z, 8'd12);
        rst_n = 1'b0;
        tick();
        check("midrst_assert", z, 8'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_release1", z, 8'd0);
        tick();
        check("midrst_release2", z, 8'd18);

        // Random stream: z after each edge equals the sum applied one iteration earlier.
        prev_exp = 8'd18;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            rc = WIDTH'($urandom_range(0, 255));
            drive(ra, rb, rc);
            cur_exp = WIDTH'((int'(ra) + int'(rb) + int'(rc)) % 256);
            tick();
            check($sformatf("rand%0d", i), z, prev_exp);
            prev_exp = cur_exp;
        end
        tick();
        check("rand_last", z, prev_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
